hack_vga_ctrl: RTL
==================

# hack_vga_ctrl

Scan-out controller for the Hack screen RAM. It owns the VGA-side port (port b) of the dual-port screen RAM, generates 640x480 VGA timing, and fetches screen words ahead of the beam. Each word is serialized into 16 monochrome pixels, and the 512x256 Hack image is centered in the visible area with a border around it. The block sits in the Hack top level beside the CPU; the CPU keeps exclusive use of screen RAM port a.

## Interface
Parameters:
- WIDTH, 16, screen word width; pixels per word
- S_AW, 16, screen RAM port b address width
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in clocks
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines
- IMG_W / IMG_H, 512 / 256, Hack image size in pixels
- H_OFF / V_OFF, 64 / 112, image origin inside the visible area

Ports:
- clk  in  1  pixel clock (25 MHz); the only clock
- reset  in  1  synchronous, active-high
- addr_b  out  S_AW  screen RAM port b word address
- rdata_b  in  WIDTH  screen RAM port b read data, valid 1 cycle after addr_b
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- vga_r / vga_g / vga_b  out  4 each  pixel colour
- vblank  out  1  high while v_cnt >= V_VIS

Port b write_b and wdata_b are tied to 0 at the top level. This block never writes.

## Operation
- Counters:
  - h_cnt counts 0 to H_TOT-1, where H_TOT = 800.
  - v_cnt counts 0 to V_TOT-1, where V_TOT = 525. v_cnt increments when h_cnt wraps and itself wraps to 0 after V_TOT-1.
- Sync windows:
  - hsync is asserted (0) for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, i.e. 656..751.
  - vsync is asserted (0) for lines 490..491.
- Image window:
  - img_row = v_cnt - V_OFF, valid for 0..255.
  - img_col = h_cnt - H_OFF, valid for 0..511.
  - The window is active when both are valid.
- Fetch:
  - Address arithmetic is unsigned in S_AW bits, truncating.
  - On image lines, the read for word w (0..31) is issued with addr_b = img_row*32 + w at h_cnt = H_OFF + 16*w - 2.
  - Issued reads are never repeated or skipped.
  - Outside fetch cycles, addr_b holds its last value.
- Shift register:
  - rdata_b is loaded into a WIDTH-bit shift register at the end of cycle h_cnt = H_OFF + 16*w - 1.
  - Bit 0 is the leftmost pixel.
  - The register shifts right by one every cycle in the image window.
- Colour:
  - In the image window: pixel bit 1 gives black (0x0 on r/g/b); pixel bit 0 gives white (0xF on r/g/b).
  - Visible area outside the image window (border) gives r=g=b=0x4.
  - Outside the visible area (blanking) gives r=g=b=0.
- vblank reflects the current v_cnt. The CPU-side use of vblank is TBD and must not be depended on here.

## Timing
- All outputs are registered.
  - vga_hsync, vga_vsync, vga_r/g/b and vblank at cycle t+1 reflect the counter state at cycle t.
  - addr_b is registered and appears in the cycle after the fetch condition.
  - The fetch condition is therefore evaluated at h_cnt = target-1, so that addr_b is valid at the target cycle H_OFF+16w-2.
- Pixel (0,0) appears on r/g/b in the cycle after h_cnt=64, v_cnt=112.
- Word 0 of each line is fetched at h_cnt=62. The final fetch of a line (w=31) occurs at h_cnt=558.
- Reset values: h_cnt=0, v_cnt=0, addr_b=0, shift register=0, vga_hsync=1, vga_vsync=1, vga_r/g/b=0, vblank=0.
- Reset mid-frame: state returns to the reset values on the next edge. The frame restarts at (0,0) the cycle after reset deasserts.
- End-of-line and end-of-frame counter wraps occur in the same cycle with no idle cycle.
- No pixel is lost at word boundaries: a load replaces the shift, with no shift in that cycle.
- Latency rdata_b to pixel output: the word is loaded 1 cycle after capture and first displayed 1 cycle later.

## Test plan
- Free run after reset. Measure hsync period = 800 cycles, low width = 96, falling edge at h_cnt=656. Measure vsync low = 2 lines (1600 cycles), period 420000 cycles.
- RAM model returns 0x0001 at every address -> each word's first pixel is black and the next 15 are white; row 0 shows black at x=64, 80, …, 560.
- RAM model word(a) = a -> addr_b sequence on v_cnt=113 is 32..63, with addr_b=32 observed at h_cnt=62 on that line.
- RAM returns 0xFFFF -> r/g/b=0 for x in 64..575 on lines 112..367, 0x4 on the border, 0 in blanking; no white pixel at any word boundary.
- Assert reset for 3 cycles at h_cnt=300, v_cnt=200 -> all outputs return to reset values; first hsync falling edge occurs 657 cycles after reset deasserts.
- Check vblank: it rises in the cycle after v_cnt reaches 480 and falls after the v_cnt wrap to 0.

Source files
------------

// File: rtl/hack_vga_ctrl.sv
// hack_vga_ctrl -- VGA scan-out for the Hack screen RAM.
// Generates 640x480 timing from the pixel clock. It reads screen words over
// RAM port b ahead of the beam and serializes each word into WIDTH
// monochrome pixels. The IMG_W x IMG_H image is centered with a grey border.
// Ports:
//   clk        pixel clock
//   reset      synchronous, active-high
//   addr_b     screen RAM port b word address (registered)
//   rdata_b    screen RAM port b read data, valid one cycle after addr_b
//   vga_hsync  horizontal sync, active-low (registered)
//   vga_vsync  vertical sync, active-low (registered)
//   vga_r/g/b  4-bit colour (registered)
//   vblank     high while the line counter is past the visible lines
module hack_vga_ctrl #(
    parameter int WIDTH  = 16,
    parameter int S_AW   = 16,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 256,
    parameter int H_OFF  = 64,
    parameter int V_OFF  = 112
) (
    input  logic             clk,
    input  logic             reset,
    output logic [S_AW-1:0]  addr_b,
    input  logic [WIDTH-1:0] rdata_b,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vblank
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int WORDS = IMG_W / WIDTH;

    logic [HW-1:0]    r_h_cnt;
    logic [VW-1:0]    r_v_cnt;
    logic [S_AW-1:0]  r_addr_b;
    logic [WIDTH-1:0] r_shift;
    logic             r_hsync, r_vsync, r_vblank;
    logic [3:0]       r_lvl;

    int   w_h, w_v, w_col, w_row, w_fcol, w_lcol;
    logic w_row_ok, w_col_ok, w_in_img, w_visible, w_fetch, w_load;
    logic w_hs_on, w_vs_on;
    logic [3:0] w_lvl;

    assign w_h   = int'(r_h_cnt);
    assign w_v   = int'(r_v_cnt);
    assign w_col = w_h - H_OFF;
    assign w_row = w_v - V_OFF;

    assign w_row_ok  = (w_row >= 0) && (w_row < IMG_H);
    assign w_col_ok  = (w_col >= 0) && (w_col < IMG_W);
    assign w_in_img  = w_row_ok && w_col_ok;
    assign w_visible = (w_h < H_VIS) && (w_v < V_VIS);

    // addr_b for word w must be on the bus at column 16w-2, so the registered
    // address is launched one cycle earlier, at column 16w-3.
    assign w_fcol  = w_col + 3;
    assign w_fetch = w_row_ok && (w_fcol >= 0) && (w_fcol < IMG_W) && (w_fcol % WIDTH == 0);

    // Data for word w arrives at column 16w-1; loading there makes the word's
    // bit 0 the pixel at column 16w.
    assign w_lcol = w_col + 1;
    assign w_load = w_row_ok && (w_lcol >= 0) && (w_lcol < IMG_W) && (w_lcol % WIDTH == 0);

    assign w_hs_on = (w_h >= H_VIS + H_FP) && (w_h < H_VIS + H_FP + H_SYNC);
    assign w_vs_on = (w_v >= V_VIS + V_FP) && (w_v < V_VIS + V_FP + V_SYNC);

    always_comb begin
        w_lvl = 4'h0;
        if (w_in_img)       w_lvl = r_shift[0] ? 4'h0 : 4'hF;
        else if (w_visible) w_lvl = 4'h4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_addr_b <= '0;
            r_shift  <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_vblank <= 1'b0;
            r_lvl    <= 4'h0;
        end else begin
            if (r_h_cnt == HW'(H_TOT - 1)) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == VW'(V_TOT - 1)) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (w_fetch)
                r_addr_b <= S_AW'(w_row * WORDS + w_fcol / WIDTH);

            // A load takes priority over the shift so no pixel is dropped at a
            // word boundary.
            if (w_load)        r_shift <= rdata_b;
            else if (w_in_img) r_shift <= r_shift >> 1;

            r_hsync  <= !w_hs_on;
            r_vsync  <= !w_vs_on;
            r_vblank <= (w_v >= V_VIS);
            r_lvl    <= w_lvl;
        end
    end

    assign addr_b    = r_addr_b;
    assign vga_hsync = r_hsync;
    assign vga_vsync = r_vsync;
    assign vblank    = r_vblank;
    assign vga_r     = r_lvl;
    assign vga_g     = r_lvl;
    assign vga_b     = r_lvl;
endmodule
